// File: rtl/jtbubl_vtiming.sv
// Purpose: parametrised video timing generator (pixel enables, H/V counters, blanking, sync, render line).
// Latency: flags and counters update on the pxl_cen edge; LHBL_dly/LVBL_dly lag LHBL/LVBL by BLK_DLY pixels.
// Backpressure: none, free-running timing source; consumers follow the strobes.
module jtbubl_vtiming #(
    parameter int CEN_DIV  = 8,
    parameter int H_TOTAL  = 384,
    parameter int HB_START = 255,
    parameter int HB_END   = 383,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int V_TOTAL  = 264,
    parameter int VB_START = 223,
    parameter int VB_END   = 263,
    parameter int VS_START = 232,
    parameter int VS_END   = 235,
    parameter int AHEAD    = 1,
    parameter int BLK_DLY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flip,
    output logic       pxl2_cen,
    output logic       pxl_cen,
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic [8:0] vrender1,
    output logic       LHBL,
    output logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic       HS,
    output logic       VS,
    output logic       Hinit,
    output logic       Vinit
);

    localparam int CW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CEN_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CEN_DIV / 2 - 1);

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] HB_S    = 9'(HB_START);
    localparam logic [8:0] HB_E    = 9'(HB_END);
    localparam logic [8:0] HS_S    = 9'(HS_START);
    localparam logic [8:0] HS_E    = 9'(HS_END);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] VB_S    = 9'(VB_START);
    localparam logic [8:0] VB_E    = 9'(VB_END);
    localparam logic [8:0] VS_S    = 9'(VS_START);
    localparam logic [8:0] VS_E    = 9'(VS_END);

    // Render arithmetic is done at 10 bits so vdump+1+AHEAD never overflows before the wrap.
    localparam logic [9:0] V_TOT10 = 10'(V_TOTAL);
    localparam logic [9:0] VB_S10  = 10'(VB_START);
    localparam logic [9:0] STEP10  = 10'(AHEAD + 1);

    logic [CW-1:0] cnt;
    logic [9:0]    r_sum;
    logic [9:0]    r;
    logic [9:0]    r1_sum;
    logic [9:0]    r1;
    logic [9:0]    vr_nxt;
    logic [9:0]    vr1_nxt;

    // Line/frame strobes are decoded from registered state so they coincide with the wrap edge.
    assign Hinit = pxl_cen & (hdump == H_LAST);
    assign Vinit = Hinit & (vdump == V_LAST);

    // Clock divider: registered enables, pxl_cen once per CEN_DIV clocks, pxl2_cen twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pxl_cen  <= 1'b0;
            pxl2_cen <= 1'b0;
        end else begin
            cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            pxl_cen  <= (cnt == CNT_LAST);
            pxl2_cen <= (cnt == CNT_LAST) || (cnt == CNT_HALF);
        end
    end

    // Horizontal counter plus H blank and H sync flags, advancing one pixel per pxl_cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdump <= '0;
            LHBL  <= 1'b1;
            HS    <= 1'b0;
        end else if (pxl_cen) begin
            hdump <= Hinit ? 9'd0 : hdump + 9'd1;
            if (hdump == HB_S) LHBL <= 1'b0;
            if (hdump == HB_E) LHBL <= 1'b1;
            if (hdump == HS_S) HS   <= 1'b1;
            if (hdump == HS_E) HS   <= 1'b0;
        end
    end

    // Look-ahead render line with optional vertical flip; lines past VB_START are never flipped.
    always_comb begin
        r_sum   = {1'b0, vdump} + STEP10;
        r       = (r_sum >= V_TOT10) ? r_sum - V_TOT10 : r_sum;
        r1_sum  = r + 10'd1;
        r1      = (r1_sum >= V_TOT10) ? r1_sum - V_TOT10 : r1_sum;
        vr_nxt  = (flip && (r <= VB_S10))  ? VB_S10 - r  : r;
        vr1_nxt = (flip && (r1 <= VB_S10)) ? VB_S10 - r1 : r1;
    end

    // Vertical counter, V blank/sync and render lines, advancing once per line at Hinit.
    always_ff @(posedge clk) begin
        if (rst) begin
            vdump    <= '0;
            LVBL     <= 1'b1;
            VS       <= 1'b0;
            vrender  <= 9'(AHEAD);
            vrender1 <= 9'(AHEAD + 1);
        end else if (Hinit) begin
            vdump    <= Vinit ? 9'd0 : vdump + 9'd1;
            if (vdump == VB_S) LVBL <= 1'b0;
            if (vdump == VB_E) LVBL <= 1'b1;
            if (vdump == VS_S) VS   <= 1'b1;
            if (vdump == VS_E) VS   <= 1'b0;
            vrender  <= vr_nxt[8:0];
            vrender1 <= vr1_nxt[8:0];
        end
    end

    generate
        if (BLK_DLY == 0) begin : g_no_dly
            assign LHBL_dly = LHBL;
            assign LVBL_dly = LVBL;
        end else begin : g_dly
            logic [BLK_DLY-1:0] hb_sr;
            logic [BLK_DLY-1:0] vb_sr;

            // Blanking delay line for the colour mixer, one stage per pxl_cen, idles as "not blanking".
            always_ff @(posedge clk) begin
                if (rst) begin
                    hb_sr <= '1;
                    vb_sr <= '1;
                end else if (pxl_cen) begin
                    hb_sr[0] <= LHBL;
                    vb_sr[0] <= LVBL;
                    for (int i = 1; i < BLK_DLY; i++) begin
                        hb_sr[i] <= hb_sr[i-1];
                        vb_sr[i] <= vb_sr[i-1];
                    end
                end
            end

            assign LHBL_dly = hb_sr[BLK_DLY-1];
            assign LVBL_dly = vb_sr[BLK_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_jtbubl_vtiming.sv
// Bench for jtbubl_vtiming: instance a uses default geometry (H timing, enables, blanking delay),
// instance b keeps default V geometry with a short 16-pixel line and BLK_DLY=0 so whole frames stay cheap.
// Expected values are hand-derived constants and ranges.
module tb_jtbubl_vtiming;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, flip_a, flip_b;

    logic       a_pxl2_cen, a_pxl_cen, a_LHBL, a_LVBL, a_LHBL_dly, a_LVBL_dly, a_HS, a_VS, a_Hinit, a_Vinit;
    logic [8:0] a_hdump, a_vdump, a_vrender, a_vrender1;
    logic       b_pxl2_cen, b_pxl_cen, b_LHBL, b_LVBL, b_LHBL_dly, b_LVBL_dly, b_HS, b_VS, b_Hinit, b_Vinit;
    logic [8:0] b_hdump, b_vdump, b_vrender, b_vrender1;

    int total = 0;
    int bad   = 0;

    logic a_hinit_s, a_vinit_s, b_hinit_s, b_vinit_s;

    jtbubl_vtiming dut_a (
        .clk(clk), .rst(rst_a), .flip(flip_a),
        .pxl2_cen(a_pxl2_cen), .pxl_cen(a_pxl_cen),
        .hdump(a_hdump), .vdump(a_vdump), .vrender(a_vrender), .vrender1(a_vrender1),
        .LHBL(a_LHBL), .LVBL(a_LVBL), .LHBL_dly(a_LHBL_dly), .LVBL_dly(a_LVBL_dly),
        .HS(a_HS), .VS(a_VS), .Hinit(a_Hinit), .Vinit(a_Vinit)
    );

    jtbubl_vtiming #(
        .CEN_DIV(4), .H_TOTAL(16), .HB_START(11), .HB_END(15), .HS_START(12), .HS_END(14),
        .BLK_DLY(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .flip(flip_b),
        .pxl2_cen(b_pxl2_cen), .pxl_cen(b_pxl_cen),
        .hdump(b_hdump), .vdump(b_vdump), .vrender(b_vrender), .vrender1(b_vrender1),
        .LHBL(b_LHBL), .LVBL(b_LVBL), .LHBL_dly(b_LHBL_dly), .LVBL_dly(b_LVBL_dly),
        .HS(b_HS), .VS(b_VS), .Hinit(b_Hinit), .Vinit(b_Vinit)
    );

    task automatic reset_a;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
    endtask

    task automatic reset_b;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
    endtask

    // Wait for the next pxl_cen cycle, latch the strobes seen there, then step past its edge.
    task automatic next_pix_a;
        int n = 0;
        while (a_pxl_cen !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (a_pxl_cen !== 1'b1) begin
            total++; bad++;
            $display("FAIL pix_a_timeout got=%b exp=1", a_pxl_cen);
        end
        a_hinit_s = a_Hinit;
        a_vinit_s = a_Vinit;
        @(posedge clk); #1;
    endtask

    task automatic next_pix_b;
        int n = 0;
        while (b_pxl_cen !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        if (b_pxl_cen !== 1'b1) begin
            total++; bad++;
            $display("FAIL pix_b_timeout got=%b exp=1", b_pxl_cen);
        end
        b_hinit_s = b_Hinit;
        b_vinit_s = b_Vinit;
        @(posedge clk); #1;
    endtask

    task automatic advance_b(input int v, input int h);
        int n = 0;
        while (!(b_vdump == 9'(v) && b_hdump == 9'(h)) && n < 20000) begin
            next_pix_b;
            n++;
        end
        if (!(b_vdump == 9'(v) && b_hdump == 9'(h))) begin
            total++; bad++;
            $display("FAIL advance_b got=%0d/%0d exp=%0d/%0d", b_vdump, b_hdump, v, h);
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_hdump !== 9'd0)    begin bad++; $display("FAIL rst_hdump got=%0d exp=0", a_hdump); end
        total++; if (a_vdump !== 9'd0)    begin bad++; $display("FAIL rst_vdump got=%0d exp=0", a_vdump); end
        total++; if (a_LHBL !== 1'b1)     begin bad++; $display("FAIL rst_lhbl got=%b exp=1", a_LHBL); end
        total++; if (a_LVBL !== 1'b1)     begin bad++; $display("FAIL rst_lvbl got=%b exp=1", a_LVBL); end
        total++; if (a_HS !== 1'b0)       begin bad++; $display("FAIL rst_hs got=%b exp=0", a_HS); end
        total++; if (a_VS !== 1'b0)       begin bad++; $display("FAIL rst_vs got=%b exp=0", a_VS); end
        total++; if (a_vrender !== 9'd1)  begin bad++; $display("FAIL rst_vrender got=%0d exp=1", a_vrender); end
        total++; if (a_vrender1 !== 9'd2) begin bad++; $display("FAIL rst_vrender1 got=%0d exp=2", a_vrender1); end
        total++; if (a_LHBL_dly !== 1'b1) begin bad++; $display("FAIL rst_lhbl_dly got=%b exp=1", a_LHBL_dly); end
        total++; if (a_LVBL_dly !== 1'b1) begin bad++; $display("FAIL rst_lvbl_dly got=%b exp=1", a_LVBL_dly); end
        total++; if (a_pxl_cen !== 1'b0)  begin bad++; $display("FAIL rst_pxl_cen got=%b exp=0", a_pxl_cen); end
        total++; if (a_pxl2_cen !== 1'b0) begin bad++; $display("FAIL rst_pxl2_cen got=%b exp=0", a_pxl2_cen); end
        total++; if (a_Hinit !== 1'b0)    begin bad++; $display("FAIL rst_hinit got=%b exp=0", a_Hinit); end
        total++; if (a_Vinit !== 1'b0)    begin bad++; $display("FAIL rst_vinit got=%b exp=0", a_Vinit); end
        total++; if (b_vrender !== 9'd1 || b_vrender1 !== 9'd2) begin
            bad++; $display("FAIL rst_b_vrender got=%0d/%0d exp=1/2", b_vrender, b_vrender1);
        end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_cen;
        int np = 0;
        int n2 = 0;
        reset_a;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            total++;
            if (a_pxl_cen !== ((k % 8) == 0)) begin
                bad++; $display("FAIL cen_pxl edge=%0d got=%b exp=%b", k, a_pxl_cen, (k % 8) == 0);
            end
            total++;
            if (a_pxl2_cen !== ((k % 4) == 0)) begin
                bad++; $display("FAIL cen_pxl2 edge=%0d got=%b exp=%b", k, a_pxl2_cen, (k % 4) == 0);
            end
            if (a_pxl_cen === 1'b1)  np++;
            if (a_pxl2_cen === 1'b1) n2++;
        end
        total++; if (np != 8)  begin bad++; $display("FAIL cen_pxl_count got=%0d exp=8", np); end
        total++; if (n2 != 16) begin bad++; $display("FAIL cen_pxl2_count got=%0d exp=16", n2); end
    endtask

    task automatic test_hline;
        reset_a;
        for (int i = 0; i < 384; i++) begin
            total++;
            if (a_hdump !== 9'(i) || a_vdump !== 9'd0) begin
                bad++; $display("FAIL hline_pos got=%0d/%0d exp=0/%0d", a_vdump, a_hdump, i);
            end
            total++;
            if (a_LHBL !== (i < 256)) begin
                bad++; $display("FAIL hline_lhbl h=%0d got=%b exp=%b", i, a_LHBL, i < 256);
            end
            total++;
            if (a_HS !== (i >= 289 && i <= 320)) begin
                bad++; $display("FAIL hline_hs h=%0d got=%b exp=%b", i, a_HS, i >= 289 && i <= 320);
            end
            total++;
            if (a_LHBL_dly !== (i < 258)) begin
                bad++; $display("FAIL hline_lhbl_dly h=%0d got=%b exp=%b", i, a_LHBL_dly, i < 258);
            end
            next_pix_a;
            total++;
            if (a_hinit_s !== (i == 383)) begin
                bad++; $display("FAIL hline_hinit h=%0d got=%b exp=%b", i, a_hinit_s, i == 383);
            end
        end
        total++; if (a_hdump !== 9'd0) begin bad++; $display("FAIL hline_wrap_h got=%0d exp=0", a_hdump); end
        total++; if (a_vdump !== 9'd1) begin bad++; $display("FAIL hline_wrap_v got=%0d exp=1", a_vdump); end
        total++; if (a_LHBL !== 1'b1)  begin bad++; $display("FAIL hline_lhbl_rise got=%b exp=1", a_LHBL); end
        total++; if (a_LHBL_dly !== 1'b0) begin bad++; $display("FAIL dly_h0 got=%b exp=0", a_LHBL_dly); end
        next_pix_a;
        total++; if (a_LHBL_dly !== 1'b0) begin bad++; $display("FAIL dly_h1 got=%b exp=0", a_LHBL_dly); end
        next_pix_a;
        total++; if (a_LHBL_dly !== 1'b1) begin bad++; $display("FAIL dly_h2 got=%b exp=1", a_LHBL_dly); end
    endtask

    task automatic test_frame;
        int hc = 0;
        int vc = 0;
        flip_b = 1'b0;
        reset_b;
        for (int v = 0; v < 264; v++) begin
            for (int h = 0; h < 16; h++) begin
                total++;
                if (b_vdump !== 9'(v) || b_hdump !== 9'(h)) begin
                    bad++; $display("FAIL frame_pos got=%0d/%0d exp=%0d/%0d", b_vdump, b_hdump, v, h);
                end
                total++;
                if (b_LVBL !== (v < 224)) begin
                    bad++; $display("FAIL frame_lvbl v=%0d got=%b exp=%b", v, b_LVBL, v < 224);
                end
                total++;
                if (b_VS !== (v >= 233 && v <= 235)) begin
                    bad++; $display("FAIL frame_vs v=%0d got=%b exp=%b", v, b_VS, v >= 233 && v <= 235);
                end
                total++;
                if (b_HS !== (h >= 13 && h <= 14)) begin
                    bad++; $display("FAIL frame_hs v=%0d h=%0d got=%b exp=%b", v, h, b_HS, h >= 13 && h <= 14);
                end
                total++;
                if (b_LHBL !== (h < 12)) begin
                    bad++; $display("FAIL frame_lhbl h=%0d got=%b exp=%b", h, b_LHBL, h < 12);
                end
                total++;
                if (b_LHBL_dly !== (h < 12) || b_LVBL_dly !== (v < 224)) begin
                    bad++; $display("FAIL frame_dly0 v=%0d h=%0d got=%b%b exp=%b%b",
                                    v, h, b_LHBL_dly, b_LVBL_dly, h < 12, v < 224);
                end
                next_pix_b;
                if (b_hinit_s === 1'b1) hc++;
                if (b_vinit_s === 1'b1) vc++;
                total++;
                if (b_vinit_s !== (v == 263 && h == 15)) begin
                    bad++; $display("FAIL frame_vinit v=%0d h=%0d got=%b", v, h, b_vinit_s);
                end
            end
        end
        total++; if (b_vdump !== 9'd0 || b_hdump !== 9'd0) begin
            bad++; $display("FAIL frame_wrap got=%0d/%0d exp=0/0", b_vdump, b_hdump);
        end
        total++; if (b_LVBL !== 1'b1) begin bad++; $display("FAIL frame_lvbl_rise got=%b exp=1", b_LVBL); end
        total++; if (hc != 264) begin bad++; $display("FAIL frame_hinit_count got=%0d exp=264", hc); end
        total++; if (vc != 1)   begin bad++; $display("FAIL frame_vinit_count got=%0d exp=1", vc); end
    endtask

    task automatic test_flip;
        flip_b = 1'b0;
        reset_b;
        advance_b(9, 0);
        total++; if (b_vrender !== 9'd10 || b_vrender1 !== 9'd11) begin
            bad++; $display("FAIL flip_v9 got=%0d/%0d exp=10/11", b_vrender, b_vrender1);
        end
        advance_b(10, 0);
        total++; if (b_vrender !== 9'd11 || b_vrender1 !== 9'd12) begin
            bad++; $display("FAIL flip0_v10 got=%0d/%0d exp=11/12", b_vrender, b_vrender1);
        end
        reset_b;
        advance_b(9, 5);
        flip_b = 1'b1;
        next_pix_b;
        total++; if (b_vrender !== 9'd10 || b_vrender1 !== 9'd11) begin
            bad++; $display("FAIL flip_midline got=%0d/%0d exp=10/11", b_vrender, b_vrender1);
        end
        advance_b(10, 0);
        total++; if (b_vrender !== 9'd212 || b_vrender1 !== 9'd211) begin
            bad++; $display("FAIL flip1_v10 got=%0d/%0d exp=212/211", b_vrender, b_vrender1);
        end
        advance_b(222, 0);
        total++; if (b_vrender !== 9'd0 || b_vrender1 !== 9'd224) begin
            bad++; $display("FAIL flip_edge got=%0d/%0d exp=0/224", b_vrender, b_vrender1);
        end
        advance_b(241, 0);
        total++; if (b_vrender !== 9'd242 || b_vrender1 !== 9'd243) begin
            bad++; $display("FAIL flip_vblank got=%0d/%0d exp=242/243", b_vrender, b_vrender1);
        end
        advance_b(0, 0);
        total++; if (b_vrender !== 9'd222 || b_vrender1 !== 9'd221) begin
            bad++; $display("FAIL flip_wrap got=%0d/%0d exp=222/221", b_vrender, b_vrender1);
        end
        flip_b = 1'b0;
    endtask

    task automatic test_reset_midframe;
        flip_b = 1'b0;
        reset_b;
        advance_b(100, 13);
        total++; if (b_HS !== 1'b1) begin bad++; $display("FAIL mid100_pre_hs got=%b exp=1", b_HS); end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        total++; if (b_hdump !== 9'd0 || b_vdump !== 9'd0) begin
            bad++; $display("FAIL mid100_pos got=%0d/%0d exp=0/0", b_vdump, b_hdump);
        end
        total++; if (b_HS !== 1'b0 || b_VS !== 1'b0) begin
            bad++; $display("FAIL mid100_sync got=%b%b exp=00", b_HS, b_VS);
        end
        total++; if (b_vrender !== 9'd1 || b_vrender1 !== 9'd2) begin
            bad++; $display("FAIL mid100_vrender got=%0d/%0d exp=1/2", b_vrender, b_vrender1);
        end
        total++; if (b_pxl_cen !== 1'b0 || b_Hinit !== 1'b0) begin
            bad++; $display("FAIL mid100_cen got=%b%b exp=00", b_pxl_cen, b_Hinit);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            total++;
            if (b_pxl_cen !== ((k % 4) == 0) || b_pxl2_cen !== ((k % 2) == 0)) begin
                bad++; $display("FAIL mid100_restart edge=%0d got=%b%b exp=%b%b",
                                k, b_pxl_cen, b_pxl2_cen, (k % 4) == 0, (k % 2) == 0);
            end
        end
        total++; if (b_hdump !== 9'd1) begin bad++; $display("FAIL mid100_hdump got=%0d exp=1", b_hdump); end

        reset_b;
        advance_b(234, 13);
        total++; if (b_LHBL !== 1'b0 || b_LVBL !== 1'b0 || b_HS !== 1'b1 || b_VS !== 1'b1) begin
            bad++; $display("FAIL mid234_pre got=%b%b%b%b exp=0011", b_LHBL, b_LVBL, b_HS, b_VS);
        end
        total++; if (b_vrender !== 9'd235) begin bad++; $display("FAIL mid234_pre_vr got=%0d exp=235", b_vrender); end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        total++; if (b_LHBL !== 1'b1 || b_LVBL !== 1'b1 || b_HS !== 1'b0 || b_VS !== 1'b0) begin
            bad++; $display("FAIL mid234_flags got=%b%b%b%b exp=1100", b_LHBL, b_LVBL, b_HS, b_VS);
        end
        total++; if (b_hdump !== 9'd0 || b_vdump !== 9'd0 || b_vrender !== 9'd1 || b_vrender1 !== 9'd2) begin
            bad++; $display("FAIL mid234_state got=%0d/%0d vr=%0d/%0d exp=0/0 vr=1/2",
                            b_vdump, b_hdump, b_vrender, b_vrender1);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; flip_a = 1'b0; flip_b = 1'b0;
        test_reset;
        test_cen;
        test_hline;
        test_frame;
        test_flip;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtbubl_vtiming.md
Name: jtbubl_vtiming

Overview:
- Parametrised video timing generator for all video sub-blocks: gfx, colmix and future tilemap/object engines.
- Derives pixel clock enables from the system clock and runs the H/V counters.
- Produces blanking, sync, frame/line init strobes, a look-ahead render line with optional flip, and a configurable-depth delayed blanking pair for the colour mixer.
- Generalises fixed-geometry timing: screen size, sync placement, render look-ahead and blanking delay are all parameters.

Parameters:
- CEN_DIV, 8: clk cycles per pxl_cen (even, ≥4).
- H_TOTAL, 384: pixels per line.
- HB_START, 255: hdump value at which H blank begins.
- HB_END, 383: hdump value at which H blank ends.
- HS_START, 288: hdump value at which HS rises.
- HS_END, 320: hdump value at which HS falls.
- V_TOTAL, 264: lines per frame.
- VB_START, 223: vdump value at which V blank begins.
- VB_END, 263: vdump value at which V blank ends.
- VS_START, 232: vdump value at which VS rises.
- VS_END, 235: vdump value at which VS falls.
- AHEAD, 1: render look-ahead in lines (0..V_TOTAL-2).
- BLK_DLY, 2: delay of LHBL_dly/LVBL_dly in pxl_cen periods (0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- flip  in  1  vertical flip of the render line.
- pxl2_cen  out  1  clock enable at 2x pixel rate.
- pxl_cen  out  1  pixel clock enable.
- hdump  out  9  current pixel.
- vdump  out  9  current line.
- vrender  out  9  line being rendered.
- vrender1  out  9  line after vrender.
- LHBL  out  1  horizontal blank, active low.
- LVBL  out  1  vertical blank, active low.
- LHBL_dly  out  1  delayed LHBL.
- LVBL_dly  out  1  delayed LVBL.
- HS  out  1  horizontal sync, active high.
- VS  out  1  vertical sync, active high.
- Hinit  out  1  line wrap strobe.
- Vinit  out  1  frame wrap strobe.

Behaviour:
Clock and reset:
- Single clock clk. rst is synchronous, active high, and has priority over all other logic.

Reset values:
- Divider cnt=0, hdump=0, vdump=0.
- LHBL=1, LVBL=1, HS=0, VS=0.
- vrender=AHEAD, vrender1=AHEAD+1.
- Delay shift registers all 1, so LHBL_dly=LVBL_dly=1.
- pxl_cen, pxl2_cen, Hinit and Vinit all 0.
- Reset mid-frame returns to exactly this state on the next clk edge.

Clock enables:
- cnt counts 0..CEN_DIV-1 and wraps.
- Registered pxl_cen=1 when the previous cnt==CEN_DIV-1.
- Registered pxl2_cen=1 when the previous cnt==CEN_DIV-1 or cnt==CEN_DIV/2-1.
- Each enable is one clk wide.
- The first pxl_cen occurs CEN_DIV clk edges after rst deasserts.

Horizontal counter:
- All counter and flag updates happen only on clk edges where pxl_cen=1.
- hdump increments and wraps from H_TOTAL-1 to 0.

Vertical counter:
- When hdump wraps, vdump increments and wraps from V_TOTAL-1 to 0.

Line and frame strobes:
- Hinit=pxl_cen & (hdump==H_TOTAL-1), combinational from registered state.
- Vinit=Hinit & (vdump==V_TOTAL-1).

Horizontal flags:
- LHBL is registered.
- At a pxl_cen with hdump==HB_START, LHBL<=0.
- At a pxl_cen with hdump==HB_END, LHBL<=1.
- With defaults, LHBL is low for hdump 256..383.
- HS<=1 at hdump==HS_START and HS<=0 at hdump==HS_END, same update rule.

Vertical flags:
- Updated only on Hinit edges.
- LVBL<=0 when vdump==VB_START; LVBL<=1 when vdump==VB_END.
- VS<=1 when vdump==VS_START; VS<=0 when vdump==VS_END.
- With defaults, LVBL is low during vdump 224..263.

Render line:
- On each Hinit edge, compute r=(vdump+1+AHEAD) mod V_TOTAL and r1=(r+1) mod V_TOTAL.
- Both sums are evaluated at 10 bits before the modulo.
- If flip=1 and r≤VB_START, vrender<=VB_START-r; otherwise vrender<=r. The same rule applies to vrender1 using r1.
- flip is sampled only at Hinit, so a mid-line flip change takes effect on the next line.

Blanking delay:
- Two BLK_DLY-stage shift registers, shifting on pxl_cen, with LHBL/LVBL as input.
- BLK_DLY=0: the _dly outputs equal LHBL/LVBL combinationally.

Simultaneous events:
- When HB_END==H_TOTAL-1, the LHBL rise, hdump wrap and vertical updates occur on the same edge, with no extra cycle.

Test Plan:
- Reset released, count 64 clk → pxl_cen pulses at clk 8,16,…,64 (eight pulses); pxl2_cen pulses at 4,8,…,64 (sixteen pulses); each pulse is 1 clk wide.
- Run 384 pxl_cen → hdump sequence 0..383 then 0; Hinit high exactly once (hdump=383); vdump goes 0→1; LHBL falls when hdump becomes 256 and rises when hdump becomes 0.
- Run a full frame of 264×384 pxl_cen:
  - LVBL falls entering vdump 224 and rises entering vdump 0.
  - VS is high during vdump 233..235.
  - Vinit is high exactly once per frame.
  - HS is high during hdump 289..320 on every line.
- flip=0 at vdump=9 → vrender=11, vrender1=12 on the next line. flip=1 at the same point → vrender=212, vrender1=211. At vdump=240, flip=1 → vrender=242 (unflipped).
- With BLK_DLY=2, LHBL falls at pxl_cen N → LHBL_dly falls at pxl_cen N+2. With BLK_DLY=0 → LHBL_dly tracks LHBL in the same cycle.
- Assert rst at vdump=100, hdump=50 for 1 clk → next edge gives hdump=0, vdump=0, LHBL=LVBL=1, HS=VS=0, vrender=1; timing restarts identically to power-up.
